// File: rtl/pipe_ctrl_buffer.sv
// pipe_ctrl_buffer: STAGES-deep stallable/flushable control-word pipeline (clk, rst, stall, flush, valid_in, ctrl_in -> valid_out, ctrl_out, occupancy)
module pipe_ctrl_buffer #(
  parameter int WIDTH = 12,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter bit FLUSH_ALL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  input  logic valid_in,
  input  logic [WIDTH-1:0] ctrl_in,
  output logic valid_out,
  output logic [WIDTH-1:0] ctrl_out,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);
  localparam int OW = $clog2(STAGES+1);
  logic [STAGES-1:0] v, vs;
  logic [STAGES-1:0][WIDTH-1:0] c, cs;
  logic in_v;
  logic [WIDTH-1:0] in_c;
  assign in_v = valid_in & ~flush;
  assign in_c = in_v ? ctrl_in : BUBBLE_VAL;
  always_comb begin
    vs[0] = in_v;
    cs[0] = in_c;
    for (int k = 1; k < STAGES; k++) begin
      vs[k] = v[k-1];
      cs[k] = c[k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst || (flush && FLUSH_ALL)) begin
      v <= '0;
      c <= {STAGES{BUBBLE_VAL}};
      occupancy <= '0;
    end else if (flush || !stall) begin
      v <= vs;
      c <= cs;
      occupancy <= occupancy + OW'(in_v) - OW'(v[STAGES-1]);
    end
  end
  assign valid_out = v[STAGES-1];
  assign ctrl_out = c[STAGES-1];
endmodule

// File: tb/tb_pipe_ctrl_buffer.sv
// tb_pipe_ctrl_buffer: checks three pipe_ctrl_buffer configurations against a slot-array reference model
module tb_pipe_ctrl_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [11:0] ctrl_in = '0;
  logic [2:0] vo;
  logic [2:0][11:0] co;
  logic [2:0][1:0] oc;
  bit mv[3][3];
  logic [11:0] mc[3][3];
  logic [11:0] bub[3] = '{12'h000, 12'h000, 12'hA5A};
  bit fa[3] = '{1'b1, 1'b0, 1'b1};
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_buffer #(.WIDTH(12), .STAGES(3), .BUBBLE_VAL(12'h000), .FLUSH_ALL(1'b1)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .valid_out(vo[0]), .ctrl_out(co[0]), .occupancy(oc[0]));
  pipe_ctrl_buffer #(.WIDTH(12), .STAGES(3), .BUBBLE_VAL(12'h000), .FLUSH_ALL(1'b0)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .valid_out(vo[1]), .ctrl_out(co[1]), .occupancy(oc[1]));
  pipe_ctrl_buffer #(.WIDTH(12), .STAGES(3), .BUBBLE_VAL(12'hA5A), .FLUSH_ALL(1'b1)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .valid_out(vo[2]), .ctrl_out(co[2]), .occupancy(oc[2]));

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst || (flush && fa[i])) begin
        for (int k = 0; k < 3; k++) begin
          mv[i][k] = 1'b0;
          mc[i][k] = bub[i];
        end
      end else if (flush || !stall) begin
        mv[i][2] = mv[i][1]; mc[i][2] = mc[i][1];
        mv[i][1] = mv[i][0]; mc[i][1] = mc[i][0];
        mv[i][0] = !flush && valid_in;
        mc[i][0] = mv[i][0] ? ctrl_in : bub[i];
      end
    end
  endtask

  task automatic chk(input string tag);
    for (int i = 0; i < 3; i++) begin
      int occ;
      occ = int'(mv[i][0]) + int'(mv[i][1]) + int'(mv[i][2]);
      n_chk++;
      assert (vo[i] === mv[i][2]) else begin
        n_fail++;
        $error("FAIL %s u%0d valid_out got %b exp %b", tag, i, vo[i], mv[i][2]);
      end
      n_chk++;
      assert (co[i] === mc[i][2]) else begin
        n_fail++;
        $error("FAIL %s u%0d ctrl_out got %h exp %h", tag, i, co[i], mc[i][2]);
      end
      n_chk++;
      assert (oc[i] === 2'(occ)) else begin
        n_fail++;
        $error("FAIL %s u%0d occupancy got %0d exp %0d", tag, i, oc[i], occ);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic r, f, s, vi, input logic [11:0] ci);
    rst = r; flush = f; stall = s; valid_in = vi; ctrl_in = ci;
    @(posedge clk);
    model_edge();
    #1;
    chk(tag);
  endtask

  initial begin
    cyc("reset0", 1, 0, 0, 0, 12'h000);
    cyc("reset1", 1, 0, 0, 0, 12'h000);
    cyc("stream1", 0, 0, 0, 1, 12'h101);
    cyc("stream2", 0, 0, 0, 1, 12'h102);
    cyc("stream3", 0, 0, 0, 1, 12'h103);
    cyc("stall1", 0, 0, 1, 1, 12'hFFF);
    cyc("stall2", 0, 0, 1, 1, 12'hFFF);
    for (int k = 0; k < 3; k++) cyc("stream_out", 0, 0, 0, 1, 12'(12'h104 + k));
    n_chk++;
    assert (oc[0] === 2'd3) else begin
      n_fail++;
      $error("FAIL full_occ got %0d exp 3", oc[0]);
    end
    cyc("reset_full", 1, 0, 0, 0, 12'h000);
    n_chk++;
    assert (vo[0] === 1'b0 && co[0] === 12'h000 && oc[0] === 2'd0) else begin
      n_fail++;
      $error("FAIL reset_full_out got %b/%h/%0d exp 0/000/0", vo[0], co[0], oc[0]);
    end
    cyc("refill1", 0, 0, 0, 1, 12'h101);
    cyc("refill2", 0, 0, 0, 1, 12'h102);
    cyc("refill3", 0, 0, 0, 1, 12'h103);
    cyc("flush_stall", 0, 1, 1, 1, 12'h3AA);
    n_chk++;
    assert (co[1] === 12'h102 && oc[1] === 2'd2) else begin
      n_fail++;
      $error("FAIL flush0 got %h/%0d exp 102/2", co[1], oc[1]);
    end
    cyc("after_flush1", 0, 0, 0, 1, 12'h201);
    cyc("after_flush2", 0, 0, 0, 1, 12'h202);
    n_chk++;
    assert (vo[1] === 1'b0 && co[1] === 12'h000) else begin
      n_fail++;
      $error("FAIL flush0_bubble got %b/%h exp 0/000", vo[1], co[1]);
    end
    cyc("bubble_in", 0, 0, 0, 0, 12'h123);
    cyc("bubble_mid1", 0, 0, 0, 1, 12'h301);
    cyc("bubble_mid2", 0, 0, 0, 1, 12'h302);
    n_chk++;
    assert (vo[2] === 1'b0 && co[2] === 12'hA5A) else begin
      n_fail++;
      $error("FAIL bubble_val got %b/%h exp 0/a5a", vo[2], co[2]);
    end
    rst = 1'b1; flush = 1'b1; stall = 1'b1;
    #3;
    chk("no_async");
    cyc("mid_reset", 1, 0, 0, 1, 12'h444);
    cyc("post_reset", 0, 0, 0, 1, 12'h555);
    for (int n = 0; n < 400; n++)
      cyc("random", ($urandom_range(31) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
          1'($urandom), 12'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
